// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned divider by repeated subtraction against an external >= comparator
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gte,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quot;

  // The comparator always sees the live working registers; its answer steers CHECK.
  assign cmp_a = rem;
  assign cmp_b = dvs;
  assign busy  = (state == S_CHECK);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem         <= '0;
      dvs         <= '0;
      quot        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem  <= dividend;
            dvs  <= divisor;
            quot <= '0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              quotient    <= '0;
              remainder   <= '0;
              state       <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (cmp_gte) begin
            rem  <= rem - dvs;
            quot <= quot + ONE;
          end else begin
            quotient  <= quot;
            remainder <= rem;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_gte;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in for the downstream 8-bit >= comparator.
  assign cmp_gte = (cmp_a >= cmp_b);

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gte(cmp_gte),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the block in IDLE; returns #1 after the edge following DONE.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b, input bit disturb);
    int exp_q, exp_r, exp_lat, exp_busy, cyc, busy_cnt;
    bit seen, exp_dz;
    exp_dz   = (b == 0);
    exp_q    = exp_dz ? 255 : a / b;
    exp_r    = exp_dz ? a : a % b;
    exp_lat  = exp_dz ? 1 : exp_q + 2;
    exp_busy = exp_dz ? 0 : exp_q + 1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        if (disturb && cyc == 4) begin
          start = 1'b1; dividend = 8'd20; divisor = 8'd4;
        end else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".busy_cycles"}, busy_cnt, exp_busy);
    check({tag, ".quotient"}, quotient, exp_q);
    check({tag, ".remainder"}, remainder, exp_r);
    check({tag, ".div_by_zero"}, div_by_zero, exp_dz);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".q_hold"}, quotient, exp_q);
    check({tag, ".r_hold"}, remainder, exp_r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cmp_a"}, cmp_a, 0);
    check({tag, ".cmp_b"}, cmp_b, 0);
    check({tag, ".quotient"}, quotient, 0);
    check({tag, ".remainder"}, remainder, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".div_by_zero"}, div_by_zero, 0);
  endtask

  initial begin
    int late_done;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("basic_100_7", 8'd100, 8'd7, 1'b0);
    run_div("below_5_9",   8'd5,   8'd9, 1'b0);
    run_div("equal_9_9",   8'd9,   8'd9, 1'b0);
    run_div("max_255_1",   8'd255, 8'd1, 1'b0);
    run_div("dbz_42_0",    8'd42,  8'd0, 1'b0);
    run_div("after_10_3",  8'd10,  8'd3, 1'b0);
    run_div("busy_200_3",  8'd200, 8'd3, 1'b1);
    run_div("zero_0_5",    8'd0,   8'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      run_div($sformatf("rand%0d", i), a, b, bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a long division.
    dividend = 8'd200; divisor = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("midreset.busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk); #1;
    check_zero("midreset_held");
    rst_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    check("midreset.no_done", late_done, 0);
    run_div("resume_77_8", 8'd77, 8'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
